// File: rtl/jacaranda_pkg.sv
// Shared definitions for the jacaranda Wishbone blocks: master FSM encoding
// and the default address window / timeout used by both master and slave.
package jacaranda_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR      = 32'h3000_0100;
  localparam logic [7:0]  DEFAULT_TIMEOUT_CYCLES = 8'd255;

  function automatic logic [3:0] lane_sel(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/jacaranda_wb_master.sv
// Wishbone classic initiator: turns one 8-bit core request into one 32-bit
// bus cycle with byte-lane select, ack/timeout handling and status return.
//
// state | meaning
// IDLE  | waiting for cpu_req_i; outputs quiescent
// BUS   | cyc/stb asserted, counting cycles towards timeout
// RESP  | one-cycle done (and err on timeout) pulse back to the core
module jacaranda_wb_master
  import jacaranda_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter logic [7:0]  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [7:0]  cpu_addr_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic [7:0]  cpu_rdata_o,
  output logic        cpu_busy_o,
  output logic        cpu_done_o,
  output logic        cpu_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  wbm_state_t state;
  logic [7:0] tmo_cnt;
  logic [1:0] lane_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      tmo_cnt     <= 8'd0;
      lane_q      <= 2'd0;
      cpu_rdata_o <= 8'h00;
      cpu_busy_o  <= 1'b0;
      cpu_done_o  <= 1'b0;
      cpu_err_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= 4'b0;
      wbm_adr_o   <= 32'b0;
      wbm_dat_o   <= 32'b0;
    end else begin
      cpu_done_o <= 1'b0;
      cpu_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req_i) begin
            state      <= BUS;
            cpu_busy_o <= 1'b1;
            wbm_cyc_o  <= 1'b1;
            wbm_stb_o  <= 1'b1;
            wbm_we_o   <= cpu_we_i;
            wbm_sel_o  <= lane_sel(cpu_addr_i[1:0]);
            wbm_adr_o  <= BASE_ADDR + {24'b0, cpu_addr_i[7:2], 2'b00};
            wbm_dat_o  <= {4{cpu_wdata_i}};
            lane_q     <= cpu_addr_i[1:0];
            tmo_cnt    <= 8'd0;
          end
        end
        BUS: begin
          // Ack wins over timeout when both land in the same cycle.
          if (wbm_ack_i) begin
            state      <= RESP;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            cpu_done_o <= 1'b1;
            if (!wbm_we_o) cpu_rdata_o <= wbm_dat_i[{lane_q, 3'b000} +: 8];
          end else if (tmo_cnt == TIMEOUT_CYCLES - 8'd1) begin
            state      <= RESP;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            cpu_done_o <= 1'b1;
            cpu_err_o  <= 1'b1;
            if (!wbm_we_o) cpu_rdata_o <= 8'hFF;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          cpu_busy_o <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          cpu_busy_o <= 1'b0;
          wbm_cyc_o  <= 1'b0;
          wbm_stb_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jacaranda_wb_master.sv
// Self-checking bench for jacaranda_wb_master: directed vector table, corner
// sequences and randomized transactions against a behavioural slave/model.
module tb_jacaranda_wb_master;

  localparam int TB_TIMEOUT = 4;
  localparam logic [31:0] TB_BASE = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr, cpu_wdata;
  logic [7:0]  cpu_rdata_o;
  logic        cpu_busy_o, cpu_done_o, cpu_err_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  int checks = 0;
  int errors = 0;

  jacaranda_wb_master #(
    .BASE_ADDR(TB_BASE),
    .TIMEOUT_CYCLES(8'(TB_TIMEOUT))
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata_o), .cpu_busy_o(cpu_busy_o), .cpu_done_o(cpu_done_o), .cpu_err_o(cpu_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  // Behavioural slave: acks after ws_cfg wait states; 255 means never.
  int          ws_cfg = 255;
  logic [31:0] word_cfg = 32'h0;
  logic        stray_ack = 1'b0;
  int          stb_seen = 0;

  always @(negedge clk) begin
    if (wbm_stb_o) begin
      wbm_ack_i = (ws_cfg != 255 && stb_seen == ws_cfg);
      wbm_dat_i = word_cfg;
      stb_seen++;
    end else begin
      stb_seen  = 0;
      wbm_ack_i = stray_ack;
      wbm_dat_i = 32'hDEAD_0000;
    end
  end

  // Bus monitor
  int          stb_total = 0, cyc_rise = 0, done_total = 0, hold_viol = 0;
  logic        cyc_prev = 1'b0, stb_prev = 1'b0;
  logic [31:0] mon_adr, mon_dat;
  logic [3:0]  mon_sel;
  logic        mon_we;

  always @(negedge clk) begin
    if (cpu_done_o) done_total++;
    if (wbm_cyc_o && !cyc_prev) cyc_rise++;
    if (wbm_stb_o) begin
      stb_total++;
      if (stb_prev && (wbm_adr_o !== mon_adr || wbm_dat_o !== mon_dat ||
                       wbm_sel_o !== mon_sel || wbm_we_o !== mon_we))
        hold_viol++;
      mon_adr = wbm_adr_o; mon_dat = wbm_dat_o; mon_sel = wbm_sel_o; mon_we = wbm_we_o;
    end
    cyc_prev = wbm_cyc_o;
    stb_prev = wbm_stb_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    int          ws;
    logic [31:0] word;
    logic [31:0] e_adr;
    logic [3:0]  e_sel;
    logic [31:0] e_dat;
    logic        e_err;
    logic [7:0]  e_rdata;
    int          e_cyc;
  } vec_t;

  logic [7:0] model_rdata = 8'h00;

  // Reference: rules stated in terms of arithmetic on the request.
  function automatic vec_t model(input vec_t v, input logic [7:0] prev);
    vec_t r = v;
    int lane = int'(v.addr) % 4;
    bit ok = (v.ws >= 0) && (v.ws < TB_TIMEOUT);
    r.e_adr = TB_BASE + 32'((int'(v.addr) / 4) * 4);
    r.e_sel = 4'(1 << lane);
    r.e_dat = 32'(v.wdata) * 32'h0101_0101;
    r.e_err = !ok;
    r.e_cyc = ok ? v.ws + 1 : TB_TIMEOUT;
    if (v.we) r.e_rdata = prev;
    else      r.e_rdata = ok ? 8'((v.word >> (8 * lane)) & 32'hFF) : 8'hFF;
    return r;
  endfunction

  task automatic do_txn(input vec_t v, input bit poke);
    int s0, r0, d0, h0, lat;
    bit seen;
    @(negedge clk);
    ws_cfg = v.ws; word_cfg = v.word;
    cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_req = 1'b1;
    s0 = stb_total; r0 = cyc_rise; d0 = done_total; h0 = hold_viol;
    @(posedge clk); #1 cpu_req = 1'b0;
    lat = 0; seen = 0;
    while (lat < 20 && !seen) begin
      @(negedge clk);
      if (cpu_done_o) seen = 1;
      else begin
        if (poke) begin cpu_req = 1'b1; cpu_addr = ~v.addr; cpu_we = ~v.we; end
        @(posedge clk); #1 cpu_req = 1'b0;
        lat++;
      end
    end
    if (poke) cpu_req = 1'b1;
    chk("done_latency", 32'(lat), 32'(v.e_cyc));
    chk("err", {31'b0, cpu_err_o}, {31'b0, v.e_err});
    chk("rdata", {24'b0, cpu_rdata_o}, {24'b0, v.e_rdata});
    chk("cyc_in_resp", {31'b0, wbm_cyc_o}, 32'd0);
    chk("stb_cycles", 32'(stb_total - s0), 32'(v.e_cyc));
    chk("adr", mon_adr, v.e_adr);
    chk("sel", {28'b0, mon_sel}, {28'b0, v.e_sel});
    chk("dat_o", mon_dat, v.e_dat);
    chk("we", {31'b0, mon_we}, {31'b0, v.we});
    chk("bus_hold", 32'(hold_viol - h0), 32'd0);
    @(posedge clk); #1 cpu_req = 1'b0;
    @(negedge clk);
    chk("busy_after", {31'b0, cpu_busy_o}, 32'd0);
    chk("done_pulse", {31'b0, cpu_done_o}, 32'd0);
    if (poke) begin
      repeat (4) @(negedge clk);
      chk("poke_bus_cycles", 32'(cyc_rise - r0), 32'd1);
      chk("poke_done_count", 32'(done_total - d0), 32'd1);
    end
    model_rdata = v.e_rdata;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cyc"},   {31'b0, wbm_cyc_o},  32'd0);
    chk({tag, "_stb"},   {31'b0, wbm_stb_o},  32'd0);
    chk({tag, "_we"},    {31'b0, wbm_we_o},   32'd0);
    chk({tag, "_sel"},   {28'b0, wbm_sel_o},  32'd0);
    chk({tag, "_adr"},   wbm_adr_o,           32'd0);
    chk({tag, "_dat"},   wbm_dat_o,           32'd0);
    chk({tag, "_rdata"}, {24'b0, cpu_rdata_o}, 32'd0);
    chk({tag, "_busy"},  {31'b0, cpu_busy_o}, 32'd0);
    chk({tag, "_done"},  {31'b0, cpu_done_o}, 32'd0);
    chk({tag, "_err"},   {31'b0, cpu_err_o},  32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    int d0, r0;

    tbl[0] = '{1'b1, 8'h05, 8'hA5, 0,   32'h0,         32'h3000_0104, 4'b0010, 32'hA5A5_A5A5, 1'b0, 8'h00, 1};
    tbl[1] = '{1'b0, 8'h07, 8'h00, 3,   32'h1122_3344, 32'h3000_0104, 4'b1000, 32'h0,         1'b0, 8'h11, 4};
    tbl[2] = '{1'b0, 8'h02, 8'h00, 255, 32'h0,         32'h3000_0100, 4'b0100, 32'h0,         1'b1, 8'hFF, 4};
    tbl[3] = '{1'b0, 8'h00, 8'h00, 0,   32'hDEAD_BEEF, 32'h3000_0100, 4'b0001, 32'h0,         1'b0, 8'hEF, 1};
    tbl[4] = '{1'b0, 8'h01, 8'h00, 1,   32'hDEAD_BEEF, 32'h3000_0100, 4'b0010, 32'h0,         1'b0, 8'hBE, 2};
    tbl[5] = '{1'b0, 8'h06, 8'h00, 2,   32'hDEAD_BEEF, 32'h3000_0104, 4'b0100, 32'h0,         1'b0, 8'hAD, 3};
    tbl[6] = '{1'b0, 8'h03, 8'h00, 0,   32'hDEAD_BEEF, 32'h3000_0100, 4'b1000, 32'h0,         1'b0, 8'hDE, 1};
    tbl[7] = '{1'b1, 8'hFF, 8'h3C, 0,   32'h0,         32'h3000_01FC, 4'b1000, 32'h3C3C_3C3C, 1'b0, 8'hDE, 1};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Directed vectors, issued back to back
    for (int i = 0; i < 8; i++) do_txn(tbl[i], 1'b0);

    // Extra requests while busy are dropped
    v = '{1'b0, 8'h09, 8'h00, 2, 32'h5566_7788, 32'h0, 4'h0, 32'h0, 1'b0, 8'h00, 0};
    do_txn(model(v, model_rdata), 1'b1);

    // Stray ack in IDLE produces nothing
    d0 = done_total; r0 = cyc_rise;
    @(negedge clk); stray_ack = 1'b1;
    repeat (4) @(negedge clk);
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_ack_done", 32'(done_total - d0), 32'd0);
    chk("stray_ack_cyc", 32'(cyc_rise - r0), 32'd0);

    // Randomized transactions against the model
    for (int i = 0; i < 30; i++) begin
      v.we = 1'($urandom_range(0, 1));
      v.addr = 8'($urandom);
      v.wdata = 8'($urandom);
      v.ws = int'($urandom_range(0, 5));
      v.word = $urandom;
      do_txn(model(v, model_rdata), 1'b0);
    end

    // Reset in the middle of a bus cycle
    @(negedge clk);
    ws_cfg = 255; cpu_we = 1'b0; cpu_addr = 8'h06; cpu_req = 1'b1;
    d0 = done_total;
    @(posedge clk); #1 cpu_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_stb", {31'b0, wbm_stb_o}, 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midbus_rst");
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midbus_rst_no_done", 32'(done_total - d0), 32'd0);
    model_rdata = 8'h00;

    v = '{1'b0, 8'h0E, 8'h00, 1, 32'hCAFE_F00D, 32'h0, 4'h0, 32'h0, 1'b0, 8'h00, 0};
    do_txn(model(v, model_rdata), 1'b0);
    v = '{1'b1, 8'h40, 8'h5A, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 8'h00, 0};
    do_txn(model(v, model_rdata), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
